// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO write port among NUM_REQ producers.
// A granted producer keeps the port until its last beat or until MAX_BEATS forces termination.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                      wr_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      err_overlength,
  output logic [15:0]               pkt_count
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        err_q, err_d;

  logic [7:0]        valid_ext, last_ext, ready_ext;
  logic [3:0]        idx;
  logic              found;
  logic [2:0]        pick;
  logic [2:0]        next_rr;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  // Pad per-requester flags to 8 bits so a 3-bit grant index selects them cleanly.
  assign valid_ext = 8'(req_valid);
  assign last_ext  = 8'(req_last);
  assign next_rr   = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 4'(rr_ptr_q) + 4'(off);
      if (idx >= 4'(NUM_REQ)) begin
        idx = idx - 4'(NUM_REQ);
      end
      if (!found && valid_ext[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    err_d       = 1'b0;
    ready_ext   = '0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StXfer;
        end
      end
      StXfer: begin
        ready_ext[grant_q] = !fifo_full;
        accept             = valid_ext[grant_q] && !fifo_full;
        if (accept) begin
          if (last_ext[grant_q]) begin
            pkt_count_d = pkt_count_q + 16'd1;
            rr_ptr_d    = next_rr;
            beat_cnt_d  = '0;
            state_d     = StIdle;
          end else if (beat_cnt_q == 8'(MAX_BEATS - 1)) begin
            // Overlong packet: drop ownership without counting it as complete.
            err_d      = 1'b1;
            rr_ptr_d   = next_rr;
            beat_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  assign req_ready      = ready_ext[NUM_REQ-1:0];
  assign fifo_wr_en     = accept;
  assign fifo_data      = accept ? sel_data : '0;
  assign grant_id       = grant_q;
  assign busy           = (state_q == StXfer);
  assign err_overlength = err_q;
  assign pkt_count      = pkt_count_q;

endmodule
